lot_occupancy: RTL

- Downstream consumer of the parking-lot gate FSM.
- Takes the FSM's one-cycle `incr` (car fully entered) and `decr` (car fully exited) pulses and keeps a saturating occupancy count.
- Raises full, empty and sticky error flags.
- Drives six active-low 7-segment digits on the board: "CLEAr0" when empty, "FULL" plus the count when full, otherwise the 2-digit decimal count.

---
 rtl/lot_occupancy.sv | 127 ++++++++++++
 1 files changed

// File: rtl/lot_occupancy.sv
// rtl/lot_occupancy.sv - saturating lot occupancy counter with flags and 7-segment display
module lot_occupancy #(
   parameter  int CAPACITY = 25,
   localparam int CW       = $clog2(CAPACITY + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          incr,
   input  logic          decr,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          overflow,
   output logic          underflow,
   output logic [6:0]    hex0,
   output logic [6:0]    hex1,
   output logic [6:0]    hex2,
   output logic [6:0]    hex3,
   output logic [6:0]    hex4,
   output logic [6:0]    hex5
);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_L     = 7'b1000111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_R     = 7'b0101111;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_U     = 7'b1000001;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [CW-1:0] CAP    = CW'(CAPACITY);

   function automatic logic [6:0] seg_digit(input logic [3:0] d);
      case (d)
         4'd0:    seg_digit = 7'b1000000;
         4'd1:    seg_digit = 7'b1111001;
         4'd2:    seg_digit = 7'b0100100;
         4'd3:    seg_digit = 7'b0110000;
         4'd4:    seg_digit = 7'b0011001;
         4'd5:    seg_digit = 7'b0010010;
         4'd6:    seg_digit = 7'b0000010;
         4'd7:    seg_digit = 7'b1111000;
         4'd8:    seg_digit = 7'b0000000;
         4'd9:    seg_digit = 7'b0010000;
         default: seg_digit = SEG_BLANK;
      endcase
   endfunction

   logic       incr_d, decr_d;
   logic       incr_ev, decr_ev;
   logic [6:0] cnt7;
   logic [3:0] tens, ones;
   logic [6:0] tens_seg;
   logic [6:0] nxt_hex0, nxt_hex1, nxt_hex2, nxt_hex3, nxt_hex4, nxt_hex5;

   assign incr_ev = incr & ~incr_d;
   assign decr_ev = decr & ~decr_d;
   assign full    = (count == CAP);
   assign empty   = (count == '0);

   // CAPACITY is at most 99, so 7 bits always hold the count for the decimal split
   assign cnt7     = 7'(count);
   assign tens     = 4'(cnt7 / 7'd10);
   assign ones     = 4'(cnt7 % 7'd10);
   assign tens_seg = (tens == 4'd0) ? SEG_BLANK : seg_digit(tens);

   always_comb begin
      nxt_hex5 = SEG_BLANK;
      nxt_hex4 = SEG_BLANK;
      nxt_hex3 = SEG_BLANK;
      nxt_hex2 = SEG_BLANK;
      nxt_hex1 = tens_seg;
      nxt_hex0 = seg_digit(ones);
      if (empty) begin
         nxt_hex5 = SEG_C;
         nxt_hex4 = SEG_L;
         nxt_hex3 = SEG_E;
         nxt_hex2 = SEG_A;
         nxt_hex1 = SEG_R;
         nxt_hex0 = SEG_ZERO;
      end else if (full) begin
         nxt_hex5 = SEG_F;
         nxt_hex4 = SEG_U;
         nxt_hex3 = SEG_L;
         nxt_hex2 = SEG_L;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         incr_d    <= 1'b0;
         decr_d    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         hex5      <= SEG_C;
         hex4      <= SEG_L;
         hex3      <= SEG_E;
         hex2      <= SEG_A;
         hex1      <= SEG_R;
         hex0      <= SEG_ZERO;
      end else begin
         incr_d <= incr;
         decr_d <= decr;
         // simultaneous entry and exit cancel out, even at the limits
         case ({incr_ev, decr_ev})
            2'b10: begin
               if (full) overflow <= 1'b1;
               else      count    <= count + 1'b1;
            end
            2'b01: begin
               if (empty) underflow <= 1'b1;
               else       count     <= count - 1'b1;
            end
            default: ;
         endcase
         hex5 <= nxt_hex5;
         hex4 <= nxt_hex4;
         hex3 <= nxt_hex3;
         hex2 <= nxt_hex2;
         hex1 <= nxt_hex1;
         hex0 <= nxt_hex0;
      end
   end

endmodule
